// File: rtl/vcm_i2c_seq.sv
// vcm_i2c_seq: I2C master sequencer for VCM driver register reads/writes with NACK retry.
// Latency: one START..STOP transaction (plus GAP and restart per NACK retry); DONE one cycle after STOP ends.
// Backpressure: CMD_READY only in IDLE; a CMD_VALID seen while BUSY is dropped, never queued.
//
// Ports:
//   CLK_50, RESET_N          single clock, synchronous active-low reset
//   CMD_VALID/CMD_READY      command handshake; CMD_RW, CMD_SLAVE, CMD_ADDR, CMD_WDATA captured on accept
//   RD_DATA                  last successful read, first received byte in the MSBs
//   DONE, NACK, BUSY         end-of-transaction pulse, error flag (valid with DONE), in-progress
//   I2C_SCL, I2C_SDA         open-drain bus, driven low or released
module vcm_i2c_seq #(
  parameter int CLK_DIV    = 31,
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 2,
  parameter int RETRIES    = 2
) (
  input  logic                                             CLK_50,
  input  logic                                             RESET_N,
  input  logic                                             CMD_VALID,
  output logic                                             CMD_READY,
  input  logic                                             CMD_RW,
  input  logic [6:0]                                       CMD_SLAVE,
  input  logic [((ADDR_BYTES == 0) ? 1 : 8*ADDR_BYTES)-1:0] CMD_ADDR,
  input  logic [8*DATA_BYTES-1:0]                          CMD_WDATA,
  output logic [8*DATA_BYTES-1:0]                          RD_DATA,
  output logic                                             DONE,
  output logic                                             NACK,
  output logic                                             BUSY,
  inout  wire                                              I2C_SCL,
  inout  wire                                              I2C_SDA
);

  localparam int AW  = (ADDR_BYTES == 0) ? 1 : 8*ADDR_BYTES;
  // Address shifter is at least one byte wide so the MSB-byte slice is always legal.
  localparam int ASW = (ADDR_BYTES == 0) ? 8 : 8*ADDR_BYTES;
  localparam int DW  = 8*DATA_BYTES;
  localparam int TW  = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int RCW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

  typedef enum logic [3:0] {
    IDLE, START, SLA_W, ACK1, REG, ACK2, WR, ACK3,
    RSTART, SLA_R, ACK4, RD, MACK, STOP, GAP
  } state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    tick;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [RCW-1:0]   retry_cnt;
  logic             nack_flag;
  logic             cmd_rw_q;
  logic [6:0]       cmd_slave_q;
  logic [AW-1:0]    cmd_addr_q;
  logic [DW-1:0]    cmd_wdata_q;
  logic [ASW-1:0]   addr_sh;
  logic [DW-1:0]    wd_sh;
  logic [DW-1:0]    rx_sh;
  logic [DW-1:0]    rd_data_q;
  logic             scl_low_q, sda_low_q;
  logic             scl_low_nx, sda_low_nx;
  logic             done_q, nack_q;
  logic [7:0]       tx_byte;

  logic wrap, q_end, sample, last_d, last_a, scl_bit, capture, ack_slot, retry_left;

  assign wrap       = (tick == TW'(CLK_DIV - 1));
  assign q_end      = wrap && (qtr == 2'd3);
  assign sample     = wrap && (qtr == 2'd2);
  assign last_d     = (byte_cnt == 2'(DATA_BYTES - 1));
  assign last_a     = (byte_cnt == 2'(ADDR_BYTES - 1));
  // Data-bit SCL shape: low in quarters 0 and 3, high in 1 and 2.
  assign scl_bit    = (qtr == 2'd0) || (qtr == 2'd3);
  assign capture    = (state == IDLE) && CMD_VALID;
  assign ack_slot   = (state == ACK1) || (state == ACK2) || (state == ACK3) || (state == ACK4);
  assign retry_left = (retry_cnt != RCW'(RETRIES));

  assign CMD_READY = (state == IDLE);
  assign BUSY      = ~CMD_READY;
  assign DONE      = done_q;
  assign NACK      = nack_q;
  assign RD_DATA   = rd_data_q;
  assign I2C_SCL   = scl_low_q ? 1'b0 : 1'bz;
  assign I2C_SDA   = sda_low_q ? 1'b0 : 1'bz;

  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      SLA_W:   tx_byte = {cmd_slave_q, 1'b0};
      SLA_R:   tx_byte = {cmd_slave_q, 1'b1};
      REG:     tx_byte = addr_sh[ASW-1 -: 8];
      WR:      tx_byte = wd_sh[DW-1 -: 8];
      default: tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    scl_low_nx = 1'b0;
    sda_low_nx = 1'b0;
    case (state)
      IDLE: if (CMD_VALID) state_nx = START;
      START: begin
        // SDA falls in quarter 2 with SCL still high, SCL drops in quarter 3.
        scl_low_nx = (qtr == 2'd3);
        sda_low_nx = qtr[1];
        if (q_end) state_nx = (cmd_rw_q && (ADDR_BYTES == 0)) ? SLA_R : SLA_W;
      end
      SLA_W, REG, WR, SLA_R: begin
        scl_low_nx = scl_bit;
        sda_low_nx = ~tx_byte[bit_cnt];
        if (q_end && (bit_cnt == 3'd0)) begin
          case (state)
            SLA_W:   state_nx = ACK1;
            REG:     state_nx = ACK2;
            WR:      state_nx = ACK3;
            default: state_nx = ACK4;
          endcase
        end
      end
      ACK1: begin
        scl_low_nx = scl_bit;
        if (q_end) state_nx = nack_flag ? STOP : ((ADDR_BYTES != 0) ? REG : WR);
      end
      ACK2: begin
        scl_low_nx = scl_bit;
        if (q_end) begin
          if (nack_flag)   state_nx = STOP;
          else if (!last_a) state_nx = REG;
          else             state_nx = cmd_rw_q ? RSTART : WR;
        end
      end
      ACK3: begin
        scl_low_nx = scl_bit;
        if (q_end) state_nx = (nack_flag || last_d) ? STOP : WR;
      end
      RSTART: begin
        // Release SDA (q0), then SCL (q1), then START condition (q2).
        scl_low_nx = scl_bit;
        sda_low_nx = qtr[1];
        if (q_end) state_nx = SLA_R;
      end
      ACK4: begin
        scl_low_nx = scl_bit;
        if (q_end) state_nx = nack_flag ? STOP : RD;
      end
      RD: begin
        scl_low_nx = scl_bit;
        if (q_end && (bit_cnt == 3'd0)) state_nx = MACK;
      end
      MACK: begin
        // Master ACK on every byte except the last, which is NACKed.
        scl_low_nx = scl_bit;
        sda_low_nx = ~last_d;
        if (q_end) state_nx = last_d ? STOP : RD;
      end
      STOP: begin
        // SCL rises in q1, SDA rises in q2 while SCL is high.
        scl_low_nx = (qtr == 2'd0);
        sda_low_nx = ~qtr[1];
        if (q_end) state_nx = (nack_flag && retry_left) ? GAP : IDLE;
      end
      GAP: if (q_end) state_nx = START;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      tick        <= '0;
      qtr         <= '0;
      bit_cnt     <= 3'd7;
      byte_cnt    <= '0;
      retry_cnt   <= '0;
      nack_flag   <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_slave_q <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      addr_sh     <= '0;
      wd_sh       <= '0;
      rx_sh       <= '0;
      rd_data_q   <= '0;
      scl_low_q   <= 1'b0;
      sda_low_q   <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      scl_low_q <= scl_low_nx;
      sda_low_q <= sda_low_nx;

      if (state == IDLE) begin
        tick <= '0;
        qtr  <= '0;
      end else if (wrap) begin
        tick <= '0;
        qtr  <= qtr + 2'd1;
      end else begin
        tick <= tick + TW'(1);
      end

      if (capture) begin
        cmd_rw_q    <= CMD_RW;
        cmd_slave_q <= CMD_SLAVE;
        cmd_addr_q  <= CMD_ADDR;
        cmd_wdata_q <= CMD_WDATA;
        retry_cnt   <= '0;
        nack_flag   <= 1'b0;
      end

      if (sample && ack_slot && I2C_SDA) nack_flag <= 1'b1;
      if (sample && (state == RD))       rx_sh <= {rx_sh[DW-2:0], I2C_SDA};

      if (q_end) begin
        case (state)
          START, RSTART: begin
            bit_cnt  <= 3'd7;
            byte_cnt <= '0;
            // Reload shifters each attempt so a retry resends the original bytes.
            if (state == START) begin
              addr_sh <= ASW'(cmd_addr_q);
              wd_sh   <= cmd_wdata_q;
            end
          end
          SLA_W, SLA_R, RD: bit_cnt <= bit_cnt - 3'd1;
          REG: begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) addr_sh <= addr_sh << 8;
          end
          WR: begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) wd_sh <= wd_sh << 8;
          end
          ACK1, ACK4: byte_cnt <= '0;
          ACK2: byte_cnt <= (state_nx == REG) ? byte_cnt + 2'd1 : 2'd0;
          ACK3: byte_cnt <= (state_nx == WR)  ? byte_cnt + 2'd1 : 2'd0;
          MACK: byte_cnt <= (state_nx == RD)  ? byte_cnt + 2'd1 : 2'd0;
          STOP: begin
            if (nack_flag && retry_left) retry_cnt <= retry_cnt + RCW'(1);
            if (!nack_flag && cmd_rw_q)  rd_data_q <= rx_sh;
          end
          GAP: nack_flag <= 1'b0;
          default: ;
        endcase
      end

      done_q <= (state == STOP) && q_end && (!nack_flag || !retry_left);
      nack_q <= (state == STOP) && q_end && nack_flag && !retry_left;
    end
  end

endmodule

// File: tb/tb_vcm_i2c_seq.sv
// tb_vcm_i2c_seq: directed bench with a behavioural I2C slave on the open-drain bus.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_vcm_i2c_seq;

  localparam int CLK_DIV = 31;
  localparam int PER     = 4*CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b0;
  logic [6:0]  cmd_slave = '0;
  logic [7:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  wire         cmd_ready, done, nack, busy;
  wire  [15:0] rd_data;
  wire         i2c_scl, i2c_sda;

  pullup (i2c_scl);
  pullup (i2c_sda);

  logic sda_drv = 1'b0;
  assign i2c_sda = sda_drv ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  vcm_i2c_seq dut (
    .CLK_50    (clk),
    .RESET_N   (rst_n),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_RW    (cmd_rw),
    .CMD_SLAVE (cmd_slave),
    .CMD_ADDR  (cmd_addr),
    .CMD_WDATA (cmd_wdata),
    .RD_DATA   (rd_data),
    .DONE      (done),
    .NACK      (nack),
    .BUSY      (busy),
    .I2C_SCL   (i2c_scl),
    .I2C_SDA   (i2c_sda)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Settings owned by the stimulus process.
  int         mark = 0;
  int         nack_cfg = 0;
  logic [6:0] sl_addr = 7'h0C;

  // Everything below is owned by the bus monitor / slave model.
  int         mark_seen = 0;
  logic [7:0] log_q[$];
  logic       mack_q[$];
  int         n_start, n_stop, n_pulse, n_gap;
  int         per_min, per_max, last_rise, stop_cyc, gap_min, gap_max;
  int         bitpos, byte_in_txn, rd_idx, nack_left;
  logic       s_scl, s_sda, prev_scl = 1'b1, prev_sda = 1'b1;
  logic       seen_rise, skip_fall, addressed, want_read, slave_tx, mack_last;
  logic [7:0] rx_sh, tx_byte;
  logic [7:0] rd_bytes [2] = '{8'hAB, 8'hCD};

  always @(negedge clk) begin
    s_scl = i2c_scl;
    s_sda = i2c_sda;
    if (mark != mark_seen) begin
      mark_seen = mark;
      log_q.delete();
      mack_q.delete();
      n_start = 0; n_stop = 0; n_pulse = 0; n_gap = 0;
      per_min = 32'h7fffffff; per_max = 0; last_rise = -1; stop_cyc = -1;
      gap_min = 32'h7fffffff; gap_max = 0;
      bitpos = 0; byte_in_txn = 0; rd_idx = 0; nack_left = nack_cfg;
      seen_rise = 0; skip_fall = 0; addressed = 0; want_read = 0; slave_tx = 0; mack_last = 1;
      sda_drv = 0;
    end
    if (s_scl && prev_scl && prev_sda && !s_sda) begin
      n_start++;
      if (stop_cyc >= 0) begin
        n_gap++;
        if (cyc - stop_cyc < gap_min) gap_min = cyc - stop_cyc;
        if (cyc - stop_cyc > gap_max) gap_max = cyc - stop_cyc;
        stop_cyc = -1;
      end
      bitpos = 0; skip_fall = 1; byte_in_txn = 0; slave_tx = 0; sda_drv = 0;
    end else if (s_scl && prev_scl && !prev_sda && s_sda) begin
      n_stop++;
      stop_cyc = cyc;
      sda_drv = 0;
      slave_tx = 0;
    end else if (!prev_scl && s_scl) begin
      if (last_rise >= 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
      seen_rise = 1;
      if (bitpos < 8 && !slave_tx) rx_sh = {rx_sh[6:0], s_sda};
      else if (bitpos == 8 && slave_tx) begin
        mack_q.push_back(s_sda);
        mack_last = s_sda;
      end
    end else if (prev_scl && !s_scl) begin
      if (seen_rise) n_pulse++;
      seen_rise = 0;
      if (skip_fall) skip_fall = 0;
      else begin
        bitpos++;
        if (bitpos == 8) begin
          if (slave_tx) sda_drv = 0;
          else begin
            log_q.push_back(rx_sh);
            if (byte_in_txn == 0) begin
              addressed = (rx_sh[7:1] == sl_addr);
              if (addressed && nack_left > 0) begin
                nack_left--;
                addressed = 0;
              end
              want_read = rx_sh[0];
            end
            sda_drv = addressed;
          end
        end else if (bitpos == 9) begin
          bitpos = 0;
          byte_in_txn++;
          sda_drv = 0;
          if (slave_tx) begin
            if (!mack_last && rd_idx < 1) begin
              rd_idx++;
              tx_byte = rd_bytes[rd_idx];
              sda_drv = !tx_byte[7];
            end else slave_tx = 0;
          end else if (addressed && want_read && byte_in_txn == 1) begin
            slave_tx = 1;
            rd_idx = 0;
            tx_byte = rd_bytes[0];
            sda_drv = !tx_byte[7];
          end
        end else if (slave_tx) sda_drv = !tx_byte[3'(7 - bitpos)];
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  function automatic logic [31:0] pack_log(input int s);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      r = {r[23:0], (s + i < log_q.size()) ? log_q[s + i] : 8'h00};
    return r;
  endfunction

  task automatic clr(input int nk);
    nack_cfg = nk;
    mark++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic rw, input logic [6:0] sl, input logic [7:0] a,
                       input logic [15:0] d, input logic hold);
    @(negedge clk);
    cmd_rw = rw; cmd_slave = sl; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic d_nack, output logic [15:0] d_rd);
    logic ok = 1'b0;
    d_nack = 1'bx;
    d_rd = 'x;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        d_nack = nack;
        d_rd = rd_data;
      end
    end
    chk({tag, "_done_seen"}, ok, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  logic        r_nack;
  logic [15:0] r_rd;
  logic [31:0] m;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_scl", i2c_scl, 1);
    chk("rst_sda", i2c_sda, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x1234 to register 0x03 of slave 0x0C.
    clr(0);
    issue(1'b0, 7'h0C, 8'h03, 16'h1234, 1'b0);
    chk("wr_ready_fall", cmd_ready, 0);
    chk("wr_busy_rise", busy, 1);
    wait_done("wr", r_nack, r_rd);
    chk("wr_nack", r_nack, 0);
    chk("wr_nbytes", log_q.size(), 4);
    chk("wr_bytes", pack_log(0), 32'h18031234);
    chk("wr_pulses", n_pulse, 36);
    chk("wr_starts", n_start, 1);
    chk("wr_stops", n_stop, 1);
    chk("wr_per_min", per_min, PER);
    chk("wr_per_max", per_max, PER);
    chk("wr_rd_data", r_rd, 16'h0000);

    // Read two bytes from register 0x05.
    clr(0);
    issue(1'b1, 7'h0C, 8'h05, 16'h0000, 1'b0);
    wait_done("rd", r_nack, r_rd);
    chk("rd_nack", r_nack, 0);
    chk("rd_nbytes", log_q.size(), 3);
    chk("rd_bytes", pack_log(0), 32'h18051900);
    chk("rd_starts", n_start, 2);
    chk("rd_stops", n_stop, 1);
    m = 32'hDEAD;
    if (mack_q.size() == 2) m = {30'b0, mack_q[0], mack_q[1]};
    chk("rd_master_ack", m, 32'h1);
    chk("rd_data", r_rd, 16'hABCD);

    // Absent slave: three attempts, then NACK reported.
    sl_addr = 7'h55;
    clr(0);
    issue(1'b1, 7'h0C, 8'h05, 16'h0000, 1'b0);
    wait_done("abs", r_nack, r_rd);
    chk("abs_nack", r_nack, 1);
    chk("abs_starts", n_start, 3);
    chk("abs_stops", n_stop, 3);
    chk("abs_nbytes", log_q.size(), 3);
    chk("abs_bytes", pack_log(0), 32'h18181800);
    chk("abs_gaps", n_gap, 2);
    chk("abs_gap_min", gap_min, 2*PER);
    chk("abs_gap_max", gap_max, 2*PER);
    chk("abs_rd_data", r_rd, 16'hABCD);

    // NACK on the first attempt only.
    sl_addr = 7'h0C;
    clr(1);
    issue(1'b0, 7'h0C, 8'h03, 16'h5678, 1'b0);
    wait_done("nk1", r_nack, r_rd);
    chk("nk1_nack", r_nack, 0);
    chk("nk1_starts", n_start, 2);
    chk("nk1_stops", n_stop, 2);
    chk("nk1_gaps", n_gap, 1);
    chk("nk1_nbytes", log_q.size(), 5);
    chk("nk1_bytes", pack_log(1), 32'h18035678);
    chk("nk1_rd_data", r_rd, 16'hABCD);

    // Reset pulse in the middle of the second data byte.
    clr(0);
    issue(1'b0, 7'h0C, 8'h03, 16'h1234, 1'b0);
    begin
      logic got3 = 1'b0;
      for (int i = 0; i < 20000 && !got3; i++) begin
        @(negedge clk);
        got3 = (log_q.size() >= 3);
      end
      chk("mr_reach_data2", got3, 1);
    end
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_scl", i2c_scl, 1);
    chk("mr_sda", i2c_sda, 1);
    chk("mr_ready", cmd_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_rd_data", rd_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clr(0);
    issue(1'b0, 7'h0C, 8'h0A, 16'hCAFE, 1'b0);
    wait_done("mr2", r_nack, r_rd);
    chk("mr2_nack", r_nack, 0);
    chk("mr2_bytes", pack_log(0), 32'h180ACAFE);
    chk("mr2_starts", n_start, 1);
    chk("mr2_stops", n_stop, 1);

    // CMD_VALID held high while busy with changing fields.
    clr(0);
    issue(1'b0, 7'h0C, 8'h07, 16'hBEEF, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cmd_rw = 1'($urandom);
      cmd_slave = 7'($urandom);
      cmd_addr = 8'($urandom);
      cmd_wdata = 16'($urandom);
    end
    cmd_valid = 1'b0;
    wait_done("hold", r_nack, r_rd);
    chk("hold_nack", r_nack, 0);
    chk("hold_nbytes", log_q.size(), 4);
    chk("hold_bytes", pack_log(0), 32'h1807BEEF);
    chk("hold_starts", n_start, 1);
    chk("hold_pulses", n_pulse, 36);
    chk("hold_per_min", per_min, PER);
    chk("hold_per_max", per_max, PER);
    chk("hold_rd_data", r_rd, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
